// File: rtl/sram_pkg.sv
// Shared constants for the dual-port pipelined SRAM: default lane width
// and the legal read-latency settings.
package sram_pkg;

   localparam int LANE_W_DEF = 8;
   localparam int RD_LAT_1   = 1;
   localparam int RD_LAT_2   = 2;

endpackage

// File: rtl/sram_be_merge.sv
// Lane merge: each lane takes the new word where its byte enable is set,
// otherwise keeps the old word.
module sram_be_merge #(
   parameter int DWIDTH = 56,
   parameter int LANE_W = 8
) (
   input  logic [DWIDTH-1:0]        old_word,
   input  logic [DWIDTH-1:0]        new_word,
   input  logic [DWIDTH/LANE_W-1:0] be,
   output logic [DWIDTH-1:0]        merged
);

   localparam int NLANES = DWIDTH / LANE_W;

   // Per-lane select between old and new data
   always_comb begin
      merged = old_word;
      for (int i = 0; i < NLANES; i++) begin
         if (be[i]) begin
            merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
         end else begin
            merged[i*LANE_W +: LANE_W] = old_word[i*LANE_W +: LANE_W];
         end
      end
   end

endmodule

// File: rtl/sram_dp_pipe.sv
// Simple dual-port SRAM with byte-lane writes, pipelined reads of latency
// 1 or 2, optional write-to-read bypass and a collision flag.
module sram_dp_pipe
   import sram_pkg::*;
#(
   parameter int DWIDTH     = 56,
   parameter int AWIDTH     = 8,
   parameter int LANE_W     = LANE_W_DEF,
   parameter int RD_LATENCY = RD_LAT_1,
   parameter int BYPASS     = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [DWIDTH/LANE_W-1:0] be,
   input  logic [AWIDTH-1:0]        addr_w,
   input  logic [DWIDTH-1:0]        data_i,
   input  logic                     re,
   input  logic [AWIDTH-1:0]        addr_r,
   output logic [DWIDTH-1:0]        data_o,
   output logic                     rd_valid,
   output logic                     collision
);

   localparam int NLANES = DWIDTH / LANE_W;
   localparam int DEPTH  = 2 ** AWIDTH;

   if ((RD_LATENCY != RD_LAT_1) && (RD_LATENCY != RD_LAT_2)) begin : g_bad_latency
      $error("sram_dp_pipe: RD_LATENCY must be 1 or 2");
   end
   if ((DWIDTH % LANE_W) != 0) begin : g_bad_lanes
      $error("sram_dp_pipe: DWIDTH must be a multiple of LANE_W");
   end

   logic [DWIDTH-1:0] mem_r [DEPTH];

   logic [DWIDTH-1:0] wr_old_s;
   logic [DWIDTH-1:0] wr_word_s;
   logic [DWIDTH-1:0] rd_old_s;
   logic [DWIDTH-1:0] rd_byp_s;
   logic [DWIDTH-1:0] rd_word_s;
   logic              coll_s;

   logic              s1_valid_r;
   logic [DWIDTH-1:0] s1_data_r;
   logic              collision_r;

   assign wr_old_s = mem_r[addr_w];
   assign rd_old_s = mem_r[addr_r];

   sram_be_merge #(.DWIDTH(DWIDTH), .LANE_W(LANE_W)) u_wr_merge (
      .old_word (wr_old_s),
      .new_word (data_i),
      .be       (be),
      .merged   (wr_word_s)
   );

   sram_be_merge #(.DWIDTH(DWIDTH), .LANE_W(LANE_W)) u_byp_merge (
      .old_word (rd_old_s),
      .new_word (data_i),
      .be       (be),
      .merged   (rd_byp_s)
   );

   // Collision detect and read-word select (old word unless bypassing)
   always_comb begin
      coll_s = we && re && (addr_r == addr_w) && (be != {NLANES{1'b0}});
      if ((BYPASS != 0) && coll_s) begin
         rd_word_s = rd_byp_s;
      end else begin
         rd_word_s = rd_old_s;
      end
   end

   // Array write; storage is deliberately never reset
   always_ff @(posedge clk) begin
      if (we && (be != {NLANES{1'b0}})) begin
         mem_r[addr_w] <= wr_word_s;
      end
   end

   // Array-read stage: data only advances on an accepted read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r  <= 1'b0;
         s1_data_r   <= {DWIDTH{1'b0}};
         collision_r <= 1'b0;
      end else begin
         s1_valid_r  <= re;
         collision_r <= coll_s;
         if (re) begin
            s1_data_r <= rd_word_s;
         end
      end
   end

   assign collision = collision_r;

   if (RD_LATENCY == RD_LAT_2) begin : g_lat2
      logic              s2_valid_r;
      logic [DWIDTH-1:0] s2_data_r;

      // Extra output register stage
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= {DWIDTH{1'b0}};
         end else begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
               s2_data_r <= s1_data_r;
            end
         end
      end

      assign data_o   = s2_data_r;
      assign rd_valid = s2_valid_r;
   end else begin : g_lat1
      assign data_o   = s1_data_r;
      assign rd_valid = s1_valid_r;
   end

endmodule

// File: tb/tb_sram_dp_pipe.sv
// Bench for sram_dp_pipe: three instances (old-data/latency 1,
// bypass/latency 1, old-data/latency 2) share one stimulus stream.
module tb_sram_dp_pipe;

   localparam int DW = 56;
   localparam int AW = 8;
   localparam int NL = 7;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              we = 1'b0;
   logic              re = 1'b0;
   logic [NL-1:0]     be = '0;
   logic [AW-1:0]     addr_w = '0;
   logic [AW-1:0]     addr_r = '0;
   logic [DW-1:0]     data_i = '0;
   logic [2:0][DW-1:0] dout;
   logic [2:0]        vld;
   logic [2:0]        col;

   int checks = 0;
   int errors = 0;
   int lat [3] = '{1, 1, 2};
   int byp [3] = '{0, 1, 0};

   typedef struct {
      logic          rd;
      logic          coll;
      logic [DW-1:0] d_old;
      logic [DW-1:0] d_new;
   } hist_t;

   hist_t         hq [$];
   logic [DW-1:0] mem_m [256];

   always #5 clk = ~clk;

   sram_dp_pipe #(.BYPASS(0), .RD_LATENCY(1)) u_b0l1 (
      .clk(clk), .rst_n(rst_n), .we(we), .be(be), .addr_w(addr_w), .data_i(data_i),
      .re(re), .addr_r(addr_r), .data_o(dout[0]), .rd_valid(vld[0]), .collision(col[0]));
   sram_dp_pipe #(.BYPASS(1), .RD_LATENCY(1)) u_b1l1 (
      .clk(clk), .rst_n(rst_n), .we(we), .be(be), .addr_w(addr_w), .data_i(data_i),
      .re(re), .addr_r(addr_r), .data_o(dout[1]), .rd_valid(vld[1]), .collision(col[1]));
   sram_dp_pipe #(.BYPASS(0), .RD_LATENCY(2)) u_b0l2 (
      .clk(clk), .rst_n(rst_n), .we(we), .be(be), .addr_w(addr_w), .data_i(data_i),
      .re(re), .addr_r(addr_r), .data_o(dout[2]), .rd_valid(vld[2]), .collision(col[2]));

   function automatic logic [DW-1:0] merge_m(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                             input logic [NL-1:0] b);
      logic [DW-1:0] r;
      r = o;
      for (int i = 0; i < NL; i++) if (b[i]) r[i*8 +: 8] = n[i*8 +: 8];
      return r;
   endfunction

   // A read issued L edges ago shows up now; data holds the last valid read.
   function automatic logic exp_valid(input int l);
      if (hq.size() < l) return 1'b0;
      return hq[hq.size()-l].rd;
   endfunction

   function automatic logic [DW-1:0] exp_data(input int l, input int b);
      for (int i = hq.size() - l; i >= 0; i--)
         if (hq[i].rd) return (b != 0) ? hq[i].d_new : hq[i].d_old;
      return '0;
   endfunction

   function automatic logic exp_coll();
      if (hq.size() == 0) return 1'b0;
      return hq[hq.size()-1].coll;
   endfunction

   task automatic tick();
      hist_t h;
      h.rd    = re;
      h.coll  = re && we && (be != '0) && (addr_r == addr_w);
      h.d_old = mem_m[addr_r];
      h.d_new = h.coll ? merge_m(mem_m[addr_r], data_i, be) : mem_m[addr_r];
      hq.push_back(h);
      if (we) mem_m[addr_w] = merge_m(mem_m[addr_w], data_i, be);
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] b);
      we = 1'b1; re = 1'b0; addr_w = a; data_i = d; be = b;
      tick();
      we = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a);
      we = 1'b0; re = 1'b1; addr_r = a;
      tick();
      re = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (dout[k] !== '0 || vld[k] !== 1'b0 || col[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset dut%0d: data=%h valid=%b coll=%b, need 0/0/0", k, dout[k], vld[k], col[k]);
         end
      end
      #1 rst_n = 1'b1;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) wr(AW'(i), 56'hC0FFEE00000000 + DW'(i), 7'h7F);
      for (int i = 0; i < 8; i++) wr(AW'(8'h80 + i), DW'({$urandom(), $urandom()}), 7'h7F);
   endtask

   task automatic test_basic();
      wr(8'h10, 56'h00112233445566, 7'h7F);
      rd(8'h10);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (vld[k] !== 1'b1 || dout[k] !== 56'h00112233445566) begin
            errors++;
            $display("FAIL basic_read dut%0d: valid=%b data=%h, need 1/00112233445566", k, vld[k], dout[k]);
         end
      end
      tick();
      checks++;
      if (vld[2] !== 1'b1 || dout[2] !== 56'h00112233445566 || vld[0] !== 1'b0 || dout[0] !== 56'h00112233445566) begin
         errors++;
         $display("FAIL basic_lat2_hold: l2 valid=%b data=%h l1 valid=%b data=%h", vld[2], dout[2], vld[0], dout[0]);
      end
   endtask

   task automatic test_partial();
      wr(8'h20, 56'hFFFFFFFFFFFFFF, 7'h7F);
      wr(8'h20, 56'h0, 7'h01);
      rd(8'h20);
      checks++;
      if (vld[0] !== 1'b1 || dout[0] !== 56'hFFFFFFFFFFFF00) begin
         errors++;
         $display("FAIL partial_write: valid=%b data=%h, need 1/FFFFFFFFFFFF00", vld[0], dout[0]);
      end
   endtask

   task automatic test_collision();
      wr(8'h30, 56'hAAAAAAAAAAAAAA, 7'h7F);
      we = 1'b1; re = 1'b1; addr_w = 8'h30; addr_r = 8'h30; data_i = 56'h55555555555555; be = 7'h7F;
      tick();
      we = 1'b0; re = 1'b0;
      checks++;
      if (dout[0] !== 56'hAAAAAAAAAAAAAA || dout[1] !== 56'h55555555555555) begin
         errors++;
         $display("FAIL coll_data: nobypass=%h bypass=%h, need AA../55..", dout[0], dout[1]);
      end
      checks++;
      if (col !== 3'b111) begin
         errors++;
         $display("FAIL coll_pulse: coll=%b, need 111", col);
      end
      tick();
      checks++;
      if (col !== 3'b000 || dout[2] !== 56'hAAAAAAAAAAAAAA) begin
         errors++;
         $display("FAIL coll_end: coll=%b l2 data=%h, need 000/AA..", col, dout[2]);
      end
      rd(8'h30);
      checks++;
      if (dout[0] !== 56'h55555555555555) begin
         errors++;
         $display("FAIL write_visible: data=%h, need 55..", dout[0]);
      end
   endtask

   task automatic test_be_zero();
      wr(8'h40, 56'h00000000001234, 7'h7F);
      we = 1'b1; re = 1'b1; addr_w = 8'h40; addr_r = 8'h40; data_i = 56'hDEADBEEFCAFE99; be = 7'h00;
      tick();
      we = 1'b0; re = 1'b0;
      checks++;
      if (col !== 3'b000 || dout[0] !== 56'h1234 || dout[1] !== 56'h1234) begin
         errors++;
         $display("FAIL be_zero: coll=%b d0=%h d1=%h, need 000/1234/1234", col, dout[0], dout[1]);
      end
      rd(8'h40);
      checks++;
      if (dout[0] !== 56'h1234 || dout[2] !== 56'h1234 || col !== 3'b000) begin
         errors++;
         $display("FAIL be_zero_later: d0=%h d2=%h coll=%b, need 1234/1234/000", dout[0], dout[2], col);
      end
   endtask

   task automatic test_back_to_back();
      tick();
      for (int t = 1; t <= 7; t++) begin
         re = (t <= 4);
         addr_r = AW'(t - 1);
         tick();
         checks++;
         if (vld[2] !== ((t >= 2) && (t <= 5))) begin
            errors++;
            $display("FAIL b2b_valid t=%0d: l2 valid=%b", t, vld[2]);
         end
         if ((t >= 2) && (t <= 5)) begin
            checks++;
            if (dout[2] !== 56'hC0FFEE00000000 + DW'(t - 2)) begin
               errors++;
               $display("FAIL b2b_data t=%0d: got %h need %h", t, dout[2], 56'hC0FFEE00000000 + DW'(t - 2));
            end
         end
      end
      re = 1'b0;
   endtask

   task automatic test_reset_inflight();
      re = 1'b1; addr_r = 8'h10;
      tick();
      addr_r = 8'h20;
      tick();
      re = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (dout !== '0 || vld !== 3'b000 || col !== 3'b000) begin
         errors++;
         $display("FAIL reset_async: data=%h valid=%b coll=%b", dout, vld, col);
      end
      hq.delete();
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int t = 0; t < 3; t++) begin
         tick();
         checks++;
         if (vld !== 3'b000 || dout !== '0) begin
            errors++;
            $display("FAIL reset_discard t=%0d: valid=%b data=%h", t, vld, dout);
         end
      end
      rd(8'h10);
      checks++;
      if (vld[0] !== 1'b1 || dout[0] !== 56'h00112233445566) begin
         errors++;
         $display("FAIL reset_resume: valid=%b data=%h", vld[0], dout[0]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         we     = 1'($urandom_range(0, 1));
         re     = 1'($urandom_range(0, 1));
         be     = NL'($urandom());
         addr_w = AW'(8'h80 + $urandom_range(0, 7));
         addr_r = AW'(8'h80 + $urandom_range(0, 7));
         data_i = DW'({$urandom(), $urandom()});
         tick();
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (vld[k] !== exp_valid(lat[k]) || dout[k] !== exp_data(lat[k], byp[k]) || col[k] !== exp_coll()) begin
               errors++;
               $display("FAIL random n=%0d dut%0d: valid=%b data=%h coll=%b, need %b %h %b", n, k,
                        vld[k], dout[k], col[k], exp_valid(lat[k]), exp_data(lat[k], byp[k]), exp_coll());
            end
         end
      end
      we = 1'b0; re = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_basic();
      test_partial();
      test_collision();
      test_be_zero();
      test_back_to_back();
      test_reset_inflight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
